// File: rtl/mc_control_unit_if.sv
// ---------------------------------------------------------------------------
// mc_control_unit_if
//   Bundles the signals exchanged between the multicycle control unit and the
//   datapath.
//
//   Signals:
//     opcode        [5:0]  instruction bits [31:26] from the instruction register
//     output_signal [15:0] control word, in the datapath's concatenation order
//     state         [3:0]  current control state encoding (debug)
//     instr_count   [W-1:0] retired-instruction counter
//     illegal_op           sticky undecodable-opcode flag
//
//   Modports:
//     master - control unit side (consumes opcode, drives everything else)
//     slave  - datapath / observer side
// ---------------------------------------------------------------------------
interface mc_control_unit_if #(
    parameter int unsigned INSTR_CNT_WIDTH = 32
);
    logic [5:0]                 opcode;
    logic [15:0]                output_signal;
    logic [3:0]                 state;
    logic [INSTR_CNT_WIDTH-1:0] instr_count;
    logic                       illegal_op;

    modport master (
        input  opcode,
        output output_signal,
        output state,
        output instr_count,
        output illegal_op
    );

    modport slave (
        output opcode,
        input  output_signal,
        input  state,
        input  instr_count,
        input  illegal_op
    );
endinterface

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//   Multicycle control FSM. Sequences fetch, decode, execute, memory and
//   write-back steps from the instruction opcode and drives the 16-bit
//   datapath control word as a Moore function of the current state.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-high reset
//     bus    - mc_control_unit_if.master (opcode in; output_signal, state,
//              instr_count, illegal_op out)
//
//   Control word order, MSB to LSB:
//     PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//     PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0], ALUSrcA, RegWrite, RegDst
//
//   Configuration:
//     MC_CTRL_ADDI_EN - when defined, opcode 001000 (ADDI) is decoded through
//                       ADDI_EX/ADDI_WB; otherwise it is an illegal opcode and
//                       encodings 10/11 behave as unused states.
// ---------------------------------------------------------------------------
module mc_control_unit #(
    parameter int unsigned INSTR_CNT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e                     state_q, state_d;
    logic [INSTR_CNT_WIDTH-1:0] count_q;
    logic                       illegal_q, illegal_d;
    logic                       retire;

    // Control word fields
    logic       pc_write_cond, pc_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [15:0] ctrl_word;

    // -----------------------------------------------------------------------
    // State, counter and sticky flag registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (retire) begin
                count_q <= count_q + 1'b1;  // wraps naturally
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = FETCH;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ADDI_EX;
`endif
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // The instruction register holds opcode stable, so only SW needs
            // to be distinguished here; LW takes the read path.
            MEMADR: state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = RWB;
`ifdef MC_CTRL_ADDI_EN
            ADDI_EX: state_d = ADDI_WB;
            ADDI_WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
`endif
            MEMWB, MEMWR, RWB, BRANCH, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore control word decode
    // -----------------------------------------------------------------------
    always_comb begin
        pc_write_cond = 1'b0;
        pc_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MC_CTRL_ADDI_EN
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDI_WB: reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

    assign ctrl_word = {pc_write_cond, pc_write, i_or_d, mem_read, mem_write,
                        mem_to_reg, ir_write, pc_source, alu_op, alu_src_b,
                        alu_src_a, reg_write, reg_dst};

    // Forced to zero combinationally during reset so no write-enable is seen
    // while reset is held, independent of the clock.
    assign bus.output_signal = reset ? '0 : ctrl_word;
    assign bus.state         = state_q;
    assign bus.instr_count   = count_q;
    assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
//   Scoreboard bench for mc_control_unit (INSTR_CNT_WIDTH = 4 so the counter
//   wraps). The driver walks each instruction through a per-opcode state list
//   and pushes the expected per-cycle observation; the monitor pops and
//   compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

    localparam int unsigned CW = 4;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] word;
        logic [3:0]  cnt;
        logic        ill;
    } exp_t;

    logic clk;
    logic reset;

    mc_control_unit_if #(.INSTR_CNT_WIDTH(CW)) bus ();

    mc_control_unit #(.INSTR_CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_total  = 0;
    int   n_passed = 0;
    int   m_cnt    = 0;     // reference model: retired count (mod 2^CW)
    bit   m_ill    = 1'b0;  // reference model: sticky illegal flag

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        else
            n_passed++;
    endtask

    // Control word per state, written from the field table as hex constants.
    function automatic logic [15:0] word_of(input int s);
        case (s)
            0:  return 16'h5208;
            1:  return 16'h0018;
            2:  return 16'h0014;
            3:  return 16'h3000;
            4:  return 16'h0402;
            5:  return 16'h2800;
            6:  return 16'h0044;
            7:  return 16'h0003;
            8:  return 16'h80A4;
            9:  return 16'h4100;
`ifdef MC_CTRL_ADDI_EN
            10: return 16'h0014;
            11: return 16'h0002;
`endif
            default: return 16'h0000;
        endcase
    endfunction

    // Visited-state list of an instruction, FETCH to terminal inclusive.
    task automatic seq_of(input logic [5:0] op, output int s[$]);
        s = {};
        case (op)
            6'b000000: s = '{0, 1, 6, 7};
            6'b100011: s = '{0, 1, 2, 3, 4};
            6'b101011: s = '{0, 1, 2, 5};
            6'b000100: s = '{0, 1, 8};
            6'b000010: s = '{0, 1, 9};
`ifdef MC_CTRL_ADDI_EN
            6'b001000: s = '{0, 1, 10, 11};
`endif
            default:   s = '{0, 1};
        endcase
    endtask

    task automatic push_exp(input int s, input logic [15:0] w);
        exp_t e;
        e.st   = s[3:0];
        e.word = w;
        e.cnt  = m_cnt[3:0];
        e.ill  = m_ill;
        sb.push_back(e);
    endtask

    // Called at posedge+1 with the DUT in FETCH. When abort_at >= 0, reset is
    // asserted mid-cycle in that step of the sequence.
    task automatic run_instr(input logic [5:0] op, input int abort_at);
        int s[$];
        seq_of(op, s);
        for (int i = 0; i < s.size(); i++) begin
            logic [5:0] junk;
            junk = 6'($urandom);
            bus.opcode = (i == 0) ? junk : op;  // opcode is ignored in FETCH
            if (i == abort_at) begin
                m_cnt = 0;
                m_ill = 1'b0;
                push_exp(0, 16'h0000);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            push_exp(s[i], word_of(s[i]));
            @(posedge clk);
            #1;
        end
        if (s.size() == 2) m_ill = 1'b1;
        else               m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    // Monitor: compares every presented cycle against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("state",         32'(bus.state),         32'(e.st));
                chk("output_signal", 32'(bus.output_signal), 32'(e.word));
                chk("instr_count",   32'(bus.instr_count),   32'(e.cnt));
                chk("illegal_op",    32'(bus.illegal_op),    32'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops[0] = 6'b000000;
        legal_ops[1] = 6'b100011;
        legal_ops[2] = 6'b101011;
        legal_ops[3] = 6'b000100;
        legal_ops[4] = 6'b000010;
        legal_ops[5] = 6'b001000;

        reset      = 1'b1;
        bus.opcode = 6'b0;
        @(posedge clk);
        #1 push_exp(0, 16'h0000);   // reset state, word forced to zero
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed: LW, SW, R-type, BEQ, J, illegal, legal after illegal
        run_instr(6'b100011, -1);
        run_instr(6'b101011, -1);
        run_instr(6'b000000, -1);
        run_instr(6'b000100, -1);
        run_instr(6'b000010, -1);
        run_instr(6'b111111, -1);
        run_instr(6'b000000, -1);
        // LW aborted by reset while in MEMRD
        run_instr(6'b100011, 3);
        run_instr(6'b001000, -1);
        // 16 retirements from zero wrap the 4-bit count back to zero
        for (int i = 0; i < 16; i++) run_instr(6'b000010, -1);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 5)];
            else                          op = 6'($urandom);
            run_instr(op, -1);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control FSM that drives the processor datapath's control word. It sits directly upstream of the datapath. It consumes the opcode field of the instruction register and sequences fetch, decode, execute, memory and write-back steps. It produces the 16-bit control bundle in the datapath's concatenation order, plus retired-instruction and illegal-opcode status.

## Interface
- `INSTR_CNT_WIDTH`, default 32: width of the retired-instruction counter.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `opcode` in 6: instruction bits [31:26], from the instruction register output.
- `output_signal` out 16: control bundle; see field order below.
- `state` out 4: current state encoding, for debug.
- `instr_count` out `INSTR_CNT_WIDTH`: retired-instruction count.
- `illegal_op` out 1: sticky flag, set on an undecodable opcode.

Field order of `output_signal`, MSB to LSB: PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0], ALUSrcA, RegWrite, RegDst.

## Operation
The control word is a Moore function of `state` only. Every field not listed for a state is 0.

States and encodings:
- FETCH=0: MemRead, IRWrite, PCWrite=1; ALUSrcB=01; ALUSrcA=0; ALUOp=00; PCSource=00; IorD=0.
- DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD=3: MemRead=1, IorD=1.
- MEMWB=4: RegWrite=1, MemtoReg=1, RegDst=0.
- MEMWR=5: MemWrite=1, IorD=1.
- EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- RWB=7: RegWrite=1, RegDst=1, MemtoReg=0.
- BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP=9: PCWrite=1, PCSource=10.
- ADDI_EX=10: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- ADDI_WB=11: RegWrite=1, RegDst=0, MemtoReg=0.

Transitions:
- FETCH always goes to DECODE.
- DECODE decodes `opcode`:
  - 000000 goes to EXEC.
  - 100011 (LW) and 101011 (SW) go to MEMADR.
  - 000100 (BEQ) goes to BRANCH.
  - 000010 (J) goes to JUMP.
  - 001000 (ADDI) goes to ADDI_EX.
  - Any other opcode goes to FETCH.
- MEMADR goes to MEMRD for LW and to MEMWR for SW. It re-reads `opcode`, which the instruction register holds stable.
- MEMRD → MEMWB; EXEC → RWB; ADDI_EX → ADDI_WB.
- MEMWB, MEMWR, RWB, BRANCH, JUMP and ADDI_WB are terminal states. Each goes to FETCH.
- Unused encodings 12–15 go to FETCH. Their control word is all-zero.

Counters and flags:
- `instr_count` increments by 1 on every clock edge that leaves a terminal state.
- `instr_count` wraps modulo 2^`INSTR_CNT_WIDTH` with no saturation.
- An illegal opcode in DECODE sets `illegal_op`. That instruction is not counted.
- `illegal_op` clears only on reset.

## Timing
- Reset asserted: `state`=FETCH, `instr_count`=0, `illegal_op`=0. These take effect immediately, without waiting for `clk`.
- While `reset` is high, `output_signal` is forced to all-zero, so PCWrite is not asserted during reset.
- After reset deasserts, the first cycle drives the FETCH word.
- Cycles per instruction, FETCH to terminal inclusive:
  - R-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - J: 3
  - ADDI: 4
  - Illegal opcode: 2 (FETCH, DECODE).
- `opcode` is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- Reset asserted mid-instruction aborts it with no count increment. Write-enables drop in the same cycle.

## Configuration
- Macro `MC_CTRL_ADDI_EN`.
- When defined: opcode 001000 decodes to ADDI_EX, and states 10 and 11 exist.
- When undefined: 001000 is illegal, so it goes to FETCH and sets `illegal_op`. Encodings 10 and 11 behave as unused encodings.

## Test plan
- **Reset mid-run:** assert `reset` asynchronously in MEMRD → `state`=0, `output_signal`=16'h0000 before the next edge, `instr_count`=0.
- **LW then SW:** opcode 100011, then 101011 → states 0,1,2,3,4 then 0,1,2,5. MEMRD has IorD=MemRead=1; MEMWR has MemWrite=1. `instr_count`=2 after 9 cycles.
- **R-type then BEQ:** opcode 000000, then 000100 → RWB word has RegWrite=RegDst=1; BRANCH word has PCWriteCond=1, PCSource=01, ALUOp=01. Count increments by 2.
- **J:** opcode 000010 → JUMP word has PCWrite=1, PCSource=10. Returns to FETCH after 3 cycles.
- **Illegal opcode:** opcode 111111 → FETCH, DECODE, FETCH. `illegal_op`=1 and stays 1 through a following legal instruction; `instr_count` unchanged.
- **ADDI and counter wrap:** opcode 001000 → states 0,1,10,11 with `MC_CTRL_ADDI_EN` defined; illegal without it. With `INSTR_CNT_WIDTH`=4, 16 retirements return `instr_count` to 0.
